// File: rtl/mem_line_ctr.sv
// Whole-line memory controller on the cache side bus: stores write lines beat by beat
// and answers after a fixed latency, streaming read lines back little-endian.
module mem_line_ctr #(
    parameter int DATA_W     = 16,
    parameter int LINE_BYTES = 16,
    parameter int MEM_LINES  = 256,
    parameter int ADDR_W     = 10,
    parameter int DELAY      = 100
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [ADDR_W-1:0] A2,
    input  logic [1:0]        C2_IN,
    input  logic [DATA_W-1:0] D2_IN,
    output logic [1:0]        C2_OUT,
    output logic              C2_OE,
    output logic [DATA_W-1:0] D2_OUT,
    output logic              D2_OE,
    output logic              BUSY
);

    localparam int BPB    = DATA_W / 8;
    localparam int BEATS  = LINE_BYTES / BPB;
    localparam int DEPTH  = MEM_LINES * BEATS;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(DELAY + 1);
    localparam int BCNT_W = $clog2(BEATS) + 1;

    localparam logic [1:0] CMD_NOP   = 2'd0;
    localparam logic [1:0] CMD_RESP  = 2'd1;
    localparam logic [1:0] CMD_READ  = 2'd2;
    localparam logic [1:0] CMD_WRITE = 2'd3;

    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DELAY);
    localparam logic [CNT_W-1:0]  CNT_RESP  = CNT_W'(DELAY - 1);
    localparam logic [CNT_W-1:0]  CNT_RD    = CNT_W'(DELAY - 2);
    localparam logic [BCNT_W-1:0] BEAT_LAST = BCNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_DATA = 2'd1,
        WAIT    = 2'd2,
        RD_DATA = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_inc;
    logic [BCNT_W-1:0]   beat;
    logic                is_wr;
    logic [ADDR_W-1:0]   line_addr;
    logic                cmd_wr;
    logic                cmd_rd;
    logic                mem_we;
    logic [IDX_W-1:0]    wr_idx;
    logic [IDX_W-1:0]    rd_idx;
    logic [DATA_W-1:0]   mem [DEPTH];

    // Storage is beat-granular; upper address bits beyond the line count wrap away.
    function automatic logic [IDX_W-1:0] mem_index(input logic [ADDR_W-1:0] a,
                                                   input logic [BCNT_W-1:0] b);
        int unsigned idx;
        idx = 32'(a) % 32'(MEM_LINES);
        return IDX_W'(idx * 32'(BEATS) + 32'(b));
    endfunction

    assign cmd_wr  = (state == IDLE) && (C2_IN == CMD_WRITE);
    assign cmd_rd  = (state == IDLE) && (C2_IN == CMD_READ);
    assign mem_we  = cmd_wr || (state == WR_DATA);
    assign wr_idx  = cmd_wr ? mem_index(A2, BCNT_W'(0)) : mem_index(line_addr, beat);
    assign rd_idx  = mem_index(line_addr, beat);
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[wr_idx] <= D2_IN;
        end
    end

    always_ff @(posedge CLK) begin
        if (cmd_wr || cmd_rd) begin
            line_addr <= A2;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // cnt holds the number of edges since the command edge; beat indexes the next beat.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt   <= '0;
            beat  <= '0;
            is_wr <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt  <= '0;
                    beat <= BCNT_W'(1);
                    if (cmd_wr || cmd_rd) begin
                        is_wr <= cmd_wr;
                    end
                end
                WR_DATA: begin
                    cnt  <= cnt_inc;
                    beat <= beat + 1'b1;
                end
                WAIT: begin
                    cnt  <= cnt_inc;
                    beat <= '0;
                end
                RD_DATA: begin
                    beat <= beat + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (C2_IN == CMD_WRITE) begin
                    state_nxt = (BEATS == 1) ? WAIT : WR_DATA;
                end else if (C2_IN == CMD_READ) begin
                    state_nxt = WAIT;
                end
            end
            WR_DATA: begin
                if (beat == BEAT_LAST) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (is_wr && (cnt == CNT_RESP)) begin
                    state_nxt = IDLE;
                end else if (!is_wr && (cnt == CNT_RD)) begin
                    state_nxt = RD_DATA;
                end
            end
            RD_DATA: begin
                if (beat == BEAT_LAST) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decode straight from state so an asynchronous reset clears them at once.
    always_comb begin
        C2_OUT = CMD_NOP;
        C2_OE  = 1'b0;
        D2_OUT = '0;
        D2_OE  = 1'b0;
        BUSY   = (state != IDLE);
        case (state)
            WAIT: begin
                C2_OE = 1'b1;
                if (is_wr && (cnt == CNT_RESP)) begin
                    C2_OUT = CMD_RESP;
                end
            end
            RD_DATA: begin
                C2_OE  = 1'b1;
                D2_OE  = 1'b1;
                C2_OUT = CMD_RESP;
                D2_OUT = mem[rd_idx];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_line_ctr.sv
// Bench for mem_line_ctr: directed table of line transactions, reset and abort sequences,
// then random traffic checked cycle by cycle against a byte-level memory model.
module tb_mem_line_ctr;

    localparam int DATA_W     = 16;
    localparam int LINE_BYTES = 16;
    localparam int MEM_LINES  = 16;
    localparam int ADDR_W     = 10;
    localparam int DELAY      = 12;
    localparam int BPB        = DATA_W / 8;
    localparam int BEATS      = LINE_BYTES / BPB;
    localparam int OBS_W      = DATA_W + 5;

    typedef logic [BEATS*DATA_W-1:0] line_t;
    typedef struct {
        bit                wr;
        logic [ADDR_W-1:0] addr;
        line_t             data;
        int                inject;
        int                gap;
    } vec_t;

    logic              CLK = 1'b0;
    logic              RESET_N;
    logic [ADDR_W-1:0] A2;
    logic [1:0]        C2_IN;
    logic [DATA_W-1:0] D2_IN;
    logic [1:0]        C2_OUT;
    logic              C2_OE;
    logic [DATA_W-1:0] D2_OUT;
    logic              D2_OE;
    logic              BUSY;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mdl   [MEM_LINES][LINE_BYTES];
    bit         known [MEM_LINES][LINE_BYTES];
    vec_t       tbl   [10];

    mem_line_ctr #(
        .DATA_W(DATA_W), .LINE_BYTES(LINE_BYTES), .MEM_LINES(MEM_LINES),
        .ADDR_W(ADDR_W), .DELAY(DELAY)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .A2(A2), .C2_IN(C2_IN), .D2_IN(D2_IN),
        .C2_OUT(C2_OUT), .C2_OE(C2_OE), .D2_OUT(D2_OUT), .D2_OE(D2_OE), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    function automatic logic [OBS_W-1:0] obs();
        return {BUSY, C2_OE, C2_OUT, D2_OE, D2_OUT};
    endfunction

    task automatic check(input string name, input int cyc,
                         input logic [OBS_W-1:0] exp, input logic [OBS_W-1:0] care);
        logic [OBS_W-1:0] act;
        act = obs();
        checks++;
        if ((act & care) !== (exp & care)) begin
            failures++;
            $display("FAIL %s cyc=%0d got{busy,c2oe,c2out,d2oe,d2out}=%h want=%h care=%h",
                     name, cyc, act, exp, care);
        end
    endtask

    function automatic void model_write(input logic [ADDR_W-1:0] addr, input line_t d);
        int l = int'(addr) % MEM_LINES;
        for (int b = 0; b < LINE_BYTES; b++) begin
            mdl[l][b]   = d[8*b +: 8];
            known[l][b] = 1'b1;
        end
    endfunction

    function automatic void model_read(input logic [ADDR_W-1:0] addr,
                                       output line_t d, output logic [BEATS-1:0] m);
        int l = int'(addr) % MEM_LINES;
        d = '0;
        m = '1;
        for (int k = 0; k < BEATS; k++) begin
            for (int i = 0; i < BPB; i++) begin
                d[8*(k*BPB+i) +: 8] = mdl[l][k*BPB+i];
                if (!known[l][k*BPB+i]) m[k] = 1'b0;
            end
        end
    endfunction

    // Issues one command on the next edge (T0) and checks every cycle up to the
    // first edge at which a new command may be accepted; returns just before it.
    task automatic xact(input string name, input bit wr, input logic [ADDR_W-1:0] addr,
                        input line_t d, input logic [BEATS-1:0] dmask,
                        input int inject, input bit noise);
        int               n;
        int               k;
        bit               act_ph;
        logic [OBS_W-1:0] exp;
        logic [OBS_W-1:0] care;
        n = wr ? DELAY + 1 : DELAY + BEATS;
        if (wr) model_write(addr, d);
        C2_IN = wr ? 2'd3 : 2'd2;
        A2    = addr;
        D2_IN = d[DATA_W-1:0];
        for (int j = 1; j <= n; j++) begin
            @(negedge CLK);
            exp  = '0;
            care = {5'b11111, {DATA_W{1'b0}}};
            if (wr) begin
                exp[DATA_W+4]      = (j <= DELAY);
                exp[DATA_W+3]      = (j >= BEATS) && (j <= DELAY);
                exp[DATA_W+2 -: 2] = (j == DELAY) ? 2'd1 : 2'd0;
            end else begin
                act_ph        = (j < DELAY + BEATS);
                exp[DATA_W+4] = act_ph;
                exp[DATA_W+3] = act_ph;
                if (j >= DELAY && act_ph) begin
                    k                  = j - DELAY;
                    exp[DATA_W+2 -: 2] = 2'd1;
                    exp[DATA_W]        = 1'b1;
                    exp[DATA_W-1:0]    = d[k*DATA_W +: DATA_W];
                    if (dmask[k]) care[DATA_W-1:0] = '1;
                end
            end
            check(name, j, exp, care);
            C2_IN = noise ? 2'($urandom_range(0, 3)) : 2'd0;
            A2    = ADDR_W'($urandom);
            D2_IN = (wr && j < BEATS) ? d[j*DATA_W +: DATA_W] : DATA_W'($urandom);
            if (j == inject) C2_IN = wr ? 2'd2 : 2'd3;
            if (j == n) C2_IN = 2'd0;
        end
    endtask

    task automatic rd_model(input string name, input logic [ADDR_W-1:0] addr,
                            input int inject, input bit noise);
        line_t            d;
        logic [BEATS-1:0] m;
        model_read(addr, d, m);
        xact(name, 1'b0, addr, d, m, inject, noise);
    endtask

    task automatic idle(input int n, input string name);
        for (int j = 1; j <= n; j++) begin
            @(negedge CLK);
            check(name, j, '0, {5'b11111, {DATA_W{1'b0}}});
            C2_IN = 2'($urandom_range(0, 1));
            A2    = ADDR_W'($urandom);
        end
        C2_IN = 2'd0;
    endtask

    initial begin
        line_t             rd;
        logic [ADDR_W-1:0] ra;

        tbl[0] = '{1'b1, 10'h005, 128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100, 0, 0};
        tbl[1] = '{1'b0, 10'h005, 128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100, 0, 2};
        tbl[2] = '{1'b1, 10'h015, 128'hDEAD_BEEF_CAFE_F00D_1234_5678_9ABC_DEF0, 10, 1};
        tbl[3] = '{1'b0, 10'h005, 128'hDEAD_BEEF_CAFE_F00D_1234_5678_9ABC_DEF0, 0, 0};
        tbl[4] = '{1'b0, 10'h3F5, 128'hDEAD_BEEF_CAFE_F00D_1234_5678_9ABC_DEF0, 0, 3};
        tbl[5] = '{1'b1, 10'h003, 128'hFFFF_0000_FFFF_0000_A5A5_5A5A_0001_FFFE, 3, 0};
        tbl[6] = '{1'b0, 10'h003, 128'hFFFF_0000_FFFF_0000_A5A5_5A5A_0001_FFFE, 4, 1};
        tbl[7] = '{1'b1, 10'h3FF, 128'h8001_7FFE_4002_BFFD_2004_DFFB_1008_EFF7, 0, 0};
        tbl[8] = '{1'b0, 10'h00F, 128'h8001_7FFE_4002_BFFD_2004_DFFB_1008_EFF7, 0, 0};
        tbl[9] = '{1'b0, 10'h013, 128'hFFFF_0000_FFFF_0000_A5A5_5A5A_0001_FFFE, 13, 2};

        RESET_N = 1'b0;
        C2_IN   = 2'd3;
        A2      = '0;
        D2_IN   = '0;
        for (int j = 1; j <= 3; j++) begin
            @(negedge CLK);
            check("reset", j, '0, '1);
        end
        C2_IN   = 2'd0;
        RESET_N = 1'b1;
        idle(2, "post_reset");

        for (int i = 0; i < 10; i++) begin
            xact(tbl[i].wr ? "tbl_wr" : "tbl_rd", tbl[i].wr, tbl[i].addr, tbl[i].data,
                 '1, tbl[i].inject, 1'b0);
            idle(tbl[i].gap, "tbl_gap");
        end

        // Abort a write of line 2 after three beats; the unwritten tail keeps old data.
        xact("abort_pre", 1'b1, 10'h002, {BEATS{16'h5555}}, '1, 0, 1'b0);
        idle(1, "abort_gap");
        C2_IN = 2'd3;
        A2    = 10'h002;
        D2_IN = 16'hAAAA;
        for (int b = 0; b < 3 * BPB; b++) mdl[2][b] = 8'hAA;
        for (int b = 3 * BPB; b < 4 * BPB; b++) known[2][b] = 1'b0;
        for (int j = 1; j <= 3; j++) begin
            @(negedge CLK);
            check("abort_busy", j, {1'b1, {(OBS_W-1){1'b0}}}, {5'b11111, {DATA_W{1'b0}}});
            C2_IN = 2'd0;
            D2_IN = 16'hAAAA;
        end
        @(posedge CLK);
        #1 RESET_N = 1'b0;
        #1 check("abort_now", 0, '0, '1);
        @(posedge CLK);
        #1 RESET_N = 1'b1;
        idle(DELAY + 2, "abort_quiet");
        rd_model("abort_read", 10'h002, 0, 1'b0);
        idle(1, "abort_gap2");

        for (int i = 0; i < 40; i++) begin
            ra = ADDR_W'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k < BEATS; k++) rd[k*DATA_W +: DATA_W] = DATA_W'($urandom);
                xact("rnd_wr", 1'b1, ra, rd, '1, 0, 1'b1);
            end else begin
                rd_model("rnd_rd", ra, 0, 1'b1);
            end
            idle($urandom_range(0, 2), "rnd_gap");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
